// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and
// the baud-tick divider formula used by the transmitter, receiver and tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // Rounded clk cycles between oversample ticks, e.g. 100 MHz / (9600 * 16) -> 651.
    function automatic int baud_tick_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async rx pin plus a previous-sample register.
// Level out is 2 clk behind the pin; the falling-edge pulse lasts one clk.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic rx_fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle (high) level so a line held low out of reset yields one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync_o = sync_q;
    assign rx_fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 at OVERSAMPLE x bit rate; UART_RX_PARITY_EN adds an even-parity bit (8E1).
// rx_done pulses one clk after the mid-stop-bit tick; no backpressure, take rx_data on rx_done.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx),
        .rx_sync_o (rx_s),
        .rx_fall_o (rx_fall)
    );

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 par_err_q, par_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
        par_err_d   = par_err_q;

        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_M1) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        par_err_d  = 1'b0;
                        // A high line at mid start bit was only a glitch.
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        par_err_d  = (^shift_q) ^ rx_s;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        // Byte is delivered even when the stop bit is bad.
                        tick_cnt_d  = '0;
                        rx_data_d   = shift_q;
                        rx_done_d   = 1'b1;
                        frame_err_d = ~rx_s | par_err_q;
                        state_d     = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames built bit by bit from byte values, expected
// bytes and error flags queued per frame and matched against each rx_done.
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          tick;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_done;
    logic          rx_busy;
    logic          frame_err;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    int   n_done   = 0;
    logic prev_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int c;
        c    = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            c    = (c + 1) % TICK_DIV;
            tick = (c == 0);
        end
    end

    // Scoreboard: every rx_done must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (!rst && rx_done) begin
            exp_t e;
            n_done++;
            if (prev_done) check("done_pulse_width", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.e});
            end
        end
        prev_done <= rx_done;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_clks(n * BIT_CLKS);
    endtask

    // rst_bit >= 0 pulses rst in the middle of that data bit and drops the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_flip, input int rst_bit);
        logic [10:0] bits;
        int          nb;
        bit          aborted;
        exp_t        e;
        aborted  = 1'b0;
        bits     = '1;
        bits[0]  = 1'b0;
        bits[8:1] = d;
        if (PAR) begin
            bits[9]  = (^d) ^ par_flip;
            bits[10] = stop_v;
            nb       = 11;
        end else begin
            bits[9] = stop_v;
            nb      = 10;
        end
        if (rst_bit < 0) begin
            e.d = d;
            e.e = ~stop_v | (PAR & par_flip);
            exp_q.push_back(e);
            n_pushed++;
        end
        for (int i = 0; i < nb; i++) begin
            rx = aborted ? 1'b1 : bits[i];
            wait_clks(BIT_CLKS / 2);
            if (rst_bit >= 0 && i == rst_bit + 1) begin
                check("busy_before_rst", {31'd0, rx_busy}, 32'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_rx_data", {24'd0, rx_data}, 32'd0);
                check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
                check("rst_rx_done", {31'd0, rx_done}, 32'd0);
                aborted = 1'b1;
                rx      = 1'b1;
                wait_clks(BIT_CLKS / 2 - 1);
            end else begin
                if (i == 5 && rst_bit < 0) check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
                wait_clks(BIT_CLKS - BIT_CLKS / 2);
            end
        end
        check("busy_after_frame", {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       sv;
        logic       pf;
        rst = 1'b1;
        rx  = 1'b0;
        wait_clks(4);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);

        // Line low out of reset: exactly one all-zero frame with a stop error.
        begin
            exp_t e;
            e.d = 8'h00;
            e.e = 1'b1;
            exp_q.push_back(e);
            n_pushed++;
        end
        rst = 1'b0;
        wait_clks((PAR ? 14 : 13) * BIT_CLKS);
        idle_bits(2);

        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle_bits(1);

        send_frame(8'hA3, 1'b1, 1'b0, -1);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        idle_bits(1);

        // Short glitch on the line must not produce a byte.
        rx = 1'b0;
        wait_clks(4 * TICK_DIV);
        rx = 1'b1;
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        wait_clks(BIT_CLKS);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        idle_bits(1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle_bits(1);

        send_frame(8'h81, 1'b0, 1'b0, -1);
        idle_bits(1);
        check("ferr_held", {31'd0, frame_err}, 32'd1);
        send_frame(8'h42, 1'b1, 1'b0, -1);
        idle_bits(1);

        send_frame(8'hF0, 1'b1, 1'b0, 4);
        idle_bits(1);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle_bits(1);

        if (PAR) begin
            send_frame(8'h07, 1'b1, 1'b0, -1);
            idle_bits(1);
            send_frame(8'h07, 1'b1, 1'b1, -1);
            idle_bits(1);
        end

        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom_range(0, 255));
            sv = ($urandom_range(0, 5) != 0);
            pf = PAR ? ($urandom_range(0, 3) == 0) : 1'b0;
            send_frame(d, sv, pf, -1);
            // After a low stop bit the line needs a high gap to make a new start edge.
            if (!sv) idle_bits(1 + $urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 2));
        end
        idle_bits(2);

        check("pending_frames", exp_q.size(), 32'd0);
        check("done_count", n_done, n_pushed);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: deserializes an 8N1 asynchronous serial line into bytes. It is the receive end of the link driven by the team's UART transmitter and shares the same baud-tick generator. It samples `rx` at 16x oversampling and emits a one-cycle `rx_done` strobe with the received byte. Sits between the board RX pin and the byte consumer (FIFO or command decoder).

Parameters:
OVERSAMPLE, 16, number of tick pulses per bit period; must be even and >= 8
DATA_BITS, 8, data bits per frame, LSB first

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
tick  input  1  oversample strobe, one clk wide, OVERSAMPLE pulses per bit period
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received byte, held until next frame completes
rx_done  output  1  one-clk pulse, frame complete
rx_busy  output  1  high from start-bit detect until the frame ends or is aborted
frame_err  output  1  stop bit sampled 0 (or parity mismatch, see Optional Feature); valid with rx_done

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: `rx_data`=0, `rx_done`=0, `rx_busy`=0, `frame_err`=0. Synchronizer FFs and the previous-sample register reset to 1. State is IDLE. Tick and bit counters reset to 0.
- Input path: 2-FF synchronizer on `rx`. Start detection is a falling edge of the synchronized line (previous=1, current=0). A line held low out of reset therefore produces exactly one frame attempt.
- Counters advance only on cycles where `tick`=1. `tick_cnt` is log2(OVERSAMPLE) bits. `bit_cnt` is log2(DATA_BITS) bits.
- IDLE: on a falling edge, go to START, clear `tick_cnt`, set `rx_busy`=1.
- START: on the tick where `tick_cnt`==OVERSAMPLE/2-1 (mid start bit):
  - synced rx==0: go to DATA, clear `tick_cnt` and `bit_cnt`.
  - synced rx==1: false start. Go to IDLE, `rx_busy`=0, no `rx_done`.
- DATA: on the tick where `tick_cnt`==OVERSAMPLE-1, sample the bit, right-shift it into the shift register MSB, clear `tick_cnt`.
  - If `bit_cnt`==DATA_BITS-1, go to STOP. Otherwise increment `bit_cnt`.
- STOP: on the tick where `tick_cnt`==OVERSAMPLE-1 (mid stop bit):
  - In the next clk: `rx_data` <= shift register, `rx_done`=1 for exactly one clk, `frame_err` <= (sampled bit==0).
  - Go to IDLE and set `rx_busy`=0.
  - The byte is delivered even on a framing error.
- `frame_err` holds its value until the next `rx_done`.
- Leaving STOP at mid stop bit allows a back-to-back start edge half a bit later; no idle gap is required.
- `rst` asserted mid-frame: return to IDLE next clk. No `rx_done`; `rx_data` is cleared to 0.
- `tick` held at 0: FSM stalls in its current state.
- Line noise in DATA/STOP: only the midpoint sample counts (no majority vote).
- Latency: `rx_done` occurs 1 clk after the mid-stop-bit tick, i.e. about 9.5 bit periods plus 3 clk after the start-bit falling edge.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state sits between DATA and STOP. One bit is sampled at `tick_cnt`==OVERSAMPLE-1, and even parity is expected over data plus parity. `frame_err` = stop error OR parity mismatch. Frames are 8E1.
- Undefined: no PARITY state, frames are 8N1, and `frame_err` reflects the stop bit only.
- Port list is identical in both builds.

Decomposition:
- Package `uart_pkg` holds:
  - state encoding constants IDLE, START, DATA, PARITY, STOP (3-bit)
  - default OVERSAMPLE=16 and DATA_BITS=8
  - the CLK_FREQ/BAUD tick-divider formula, shared with the transmitter and the tick generator
- One sub-module, `uart_rx_sync`: 2-FF synchronizer plus previous-sample register. Outputs are the synced level and a falling-edge pulse.

Test Plan:
- Setup: clk 100 MHz, tick every 651 clk (9600 baud x16). Send 0x55, 8N1 → `rx_done` once, `rx_data`=0x55, `frame_err`=0, `rx_busy` high for about 9.5 bit times.
- Back-to-back 0xA3, 0x00, 0xFF with no idle gap → three `rx_done` pulses, data in order, `frame_err`=0 each time.
- Glitch: rx low for 4 ticks, then high → no `rx_done`; `rx_busy` pulses, then returns to 0; next valid frame 0x3C is received correctly.
- Frame 0x81 with stop bit driven 0 → `rx_done`=1, `rx_data`=0x81, `frame_err`=1. Next good frame 0x42 → `frame_err`=0.
- `rst` pulsed for 1 clk during data bit 4 of 0xF0 → no `rx_done`, `rx_data`=0, `rx_busy`=0. A following 0x0F frame is received correctly.
- UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 → `frame_err`=0.
  - 0x07 with parity bit 0 → `frame_err`=1, `rx_data`=0x07.
